// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode constants,
// FSM state encoding and the legal-opcode check.
package alu_issue_ctrl_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_XOR = 2;
    localparam int OP_AND = 3;
    localparam int OP_OR  = 4;
    localparam int OP_SHL = 11;
    localparam int OP_SHR = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } issueState_t;

    // Opcode arrives zero-extended so the check is independent of OPCODE width.
    function automatic logic isLegalOp(input logic [31:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_SHL, OP_SHR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the issue controller: two combinational read ports and
// two write ports. The write-back port wins over the external port when both
// target the same register in the same cycle.
module alu_issue_regfile #(
    parameter int BITS = 8,
    parameter int REGS = 8,
    parameter int RA   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA-1:0]   rdAddrA,
    input  logic [RA-1:0]   rdAddrB,
    output logic [BITS-1:0] rdDataA,
    output logic [BITS-1:0] rdDataB,
    input  logic            wbWe,
    input  logic [RA-1:0]   wbAddr,
    input  logic [BITS-1:0] wbData,
    input  logic            extWe,
    input  logic [RA-1:0]   extAddr,
    input  logic [BITS-1:0] extData
);

    logic [BITS-1:0] regs [REGS];

    // Per-register write with write-back priority; different addresses both land.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (wbWe && wbAddr == RA'(i))
                    regs[i] <= wbData;
                else if (extWe && extAddr == RA'(i))
                    regs[i] <= extData;
            end
        end
    end

    // Combinational operand reads.
    always_comb begin
        rdDataA = regs[rdAddrA];
        rdDataB = regs[rdAddrB];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction, reads its operands in
// ISSUE, captures the external ALU result and writes it back in WB.
// One instruction every three cycles; no buffering, no hazard logic needed.
// Optional feature: define ALU_ISSUE_FLAGS_EN to add zeroFlag/ovfFlag outputs.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter  int BITS   = 8,
    parameter  int OPCODE = 5,
    parameter  int REGS   = 8,
    localparam int RA     = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instValid,
    output logic              instReady,
    input  logic [OPCODE-1:0] instOp,
    input  logic [RA-1:0]     instRd,
    input  logic [RA-1:0]     instRs1,
    input  logic [RA-1:0]     instRs2,
    input  logic              extWe,
    input  logic [RA-1:0]     extAddr,
    input  logic [BITS-1:0]   extData,
    output logic [OPCODE-1:0] aluFunction,
    output logic [BITS-1:0]   vectorA,
    output logic [BITS-1:0]   vectorB,
    input  logic [BITS-1:0]   aluResult,
    output logic              wbValid,
    output logic [RA-1:0]     wbAddr,
    output logic [BITS-1:0]   wbData,
    output logic              illegalOp,
    output logic              busy
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic              zeroFlag,
    output logic              ovfFlag
`endif
);

    issueState_t state, nextState;

    logic [OPCODE-1:0] opQ;
    logic [RA-1:0]     rdQ, rs1Q, rs2Q;
    logic [BITS-1:0]   resultQ;
    logic              illegalQ;
    logic [BITS-1:0]   rdDataA, rdDataB;
    logic              accept, legal;

    assign accept = instValid && instReady;
    assign legal  = isLegalOp(32'(instOp));

    alu_issue_regfile #(.BITS(BITS), .REGS(REGS), .RA(RA)) uRegfile (
        .clk     (clk),
        .reset   (reset),
        .rdAddrA (rs1Q),
        .rdAddrB (rs2Q),
        .rdDataA (rdDataA),
        .rdDataB (rdDataB),
        .wbWe    (state == WB),
        .wbAddr  (rdQ),
        .wbData  (resultQ),
        .extWe   (extWe),
        .extAddr (extAddr),
        .extData (extData)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state and all state-decoded outputs; ALU-facing outputs are zero outside ISSUE.
    always_comb begin
        nextState   = state;
        instReady   = 1'b0;
        busy        = 1'b1;
        aluFunction = '0;
        vectorA     = '0;
        vectorB     = '0;
        wbValid     = 1'b0;
        wbAddr      = '0;
        wbData      = '0;
        case (state)
            IDLE: begin
                instReady = 1'b1;
                busy      = 1'b0;
                if (accept && legal) nextState = ISSUE;
            end
            ISSUE: begin
                aluFunction = opQ;
                vectorA     = rdDataA;
                vectorB     = rdDataB;
                nextState   = WB;
            end
            WB: begin
                wbValid   = 1'b1;
                wbAddr    = rdQ;
                wbData    = resultQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Instruction latch, result capture and the one-cycle reject pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opQ      <= '0;
            rdQ      <= '0;
            rs1Q     <= '0;
            rs2Q     <= '0;
            resultQ  <= '0;
            illegalQ <= 1'b0;
        end else begin
            illegalQ <= accept && !legal;
            if (accept && legal) begin
                opQ  <= instOp;
                rdQ  <= instRd;
                rs1Q <= instRs1;
                rs2Q <= instRs2;
            end
            if (state == ISSUE) resultQ <= aluResult;
        end
    end

    assign illegalOp = illegalQ;

`ifdef ALU_ISSUE_FLAGS_EN
    logic zeroQ, ovfQ;
    logic signA, signB, signR;

    assign signA = vectorA[BITS-1];
    assign signB = vectorB[BITS-1];
    assign signR = aluResult[BITS-1];

    // Flags are taken alongside the result so they are valid during WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zeroQ <= 1'b0;
            ovfQ  <= 1'b0;
        end else if (state == ISSUE) begin
            zeroQ <= (aluResult == '0);
            if (opQ == OPCODE'(OP_ADD))
                ovfQ <= (signA == signB) && (signR != signA);
            else if (opQ == OPCODE'(OP_SUB))
                ovfQ <= (signA != signB) && (signR != signA);
            else
                ovfQ <= 1'b0;
        end
    end

    assign zeroFlag = zeroQ;
    assign ovfFlag  = ovfQ;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU model drives aluResult, a register-array
// reference model predicts operands, results and flags.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instValid;
    logic       instReady;
    logic [4:0] instOp;
    logic [2:0] instRd, instRs1, instRs2;
    logic       extWe;
    logic [2:0] extAddr;
    logic [7:0] extData;
    logic [4:0] aluFunction;
    logic [7:0] vectorA, vectorB, aluResult;
    logic       wbValid;
    logic [2:0] wbAddr;
    logic [7:0] wbData;
    logic       illegalOp, busy;
`ifdef ALU_ISSUE_FLAGS_EN
    logic       zeroFlag, ovfFlag;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] refRegs [8];

    // Observations from runInst.
    logic [4:0] obsFn;
    logic [7:0] obsA, obsB, obsWbData;
    logic       obsWbV, obsReadyIssue;
    logic [2:0] obsWbAddr;
    logic       obsZero, obsOvf;

    alu_issue_ctrl #(.BITS(8), .OPCODE(5), .REGS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instValid   (instValid),
        .instReady   (instReady),
        .instOp      (instOp),
        .instRd      (instRd),
        .instRs1     (instRs1),
        .instRs2     (instRs2),
        .extWe       (extWe),
        .extAddr     (extAddr),
        .extData     (extData),
        .aluFunction (aluFunction),
        .vectorA     (vectorA),
        .vectorB     (vectorB),
        .aluResult   (aluResult),
        .wbValid     (wbValid),
        .wbAddr      (wbAddr),
        .wbData      (wbData),
        .illegalOp   (illegalOp),
        .busy        (busy)
`ifdef ALU_ISSUE_FLAGS_EN
        ,
        .zeroFlag    (zeroFlag),
        .ovfFlag     (ovfFlag)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] aluRef(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a ^ b;
            3:  return a & b;
            4:  return a | b;
            11: return (b > 7) ? 8'h00 : 8'(a << b);
            12: return (b > 7) ? 8'h00 : 8'(a >> b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic ovfRef(input int op, input logic [7:0] a, input logic [7:0] b);
        int s;
        if (op == 0) s = int'($signed(a)) + int'($signed(b));
        else if (op == 1) s = int'($signed(a)) - int'($signed(b));
        else return 1'b0;
        return (s > 127) || (s < -128);
    endfunction

    // External ALU: combinational result from what the controller presents.
    always_comb aluResult = aluRef(int'(aluFunction), vectorA, vectorB);

    function automatic int randLegalOp();
        int ops [7] = '{0, 1, 2, 3, 4, 11, 12};
        return ops[$urandom_range(0, 6)];
    endfunction

    task automatic extLoad(input int addr, input logic [7:0] data);
        @(negedge clk);
        extWe = 1'b1; extAddr = 3'(addr); extData = data;
        @(negedge clk);
        extWe = 1'b0;
        refRegs[addr] = data;
    endtask

    // Drives one instruction, samples ISSUE and WB outputs; optional ext write during WB.
    task automatic runInst(input int op, input int rd, input int rs1, input int rs2,
                           input logic wbExtWe, input int wbExtAddr, input logic [7:0] wbExtData);
        @(negedge clk);
        instValid = 1'b1; instOp = 5'(op); instRd = 3'(rd); instRs1 = 3'(rs1); instRs2 = 3'(rs2);
        @(negedge clk);
        instValid = 1'b0;
        obsFn = aluFunction; obsA = vectorA; obsB = vectorB; obsReadyIssue = instReady;
        @(negedge clk);
        obsWbV = wbValid; obsWbAddr = wbAddr; obsWbData = wbData;
`ifdef ALU_ISSUE_FLAGS_EN
        obsZero = zeroFlag; obsOvf = ovfFlag;
`else
        obsZero = 1'b0; obsOvf = 1'b0;
`endif
        extWe = wbExtWe; extAddr = 3'(wbExtAddr); extData = wbExtData;
        @(negedge clk);
        extWe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; instValid = 1'b0; instOp = '0; instRd = '0; instRs1 = '0; instRs2 = '0;
        extWe = 1'b0; extAddr = '0; extData = '0;
        for (int i = 0; i < 8; i++) refRegs[i] = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (instReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instReady); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wbValid !== 1'b0 || illegalOp !== 1'b0) begin errors++; $display("FAIL reset_pulses wbValid=%b illegalOp=%b exp=0/0", wbValid, illegalOp); end
        checks++; if (aluFunction !== 5'd0 || vectorA !== 8'd0 || vectorB !== 8'd0) begin errors++; $display("FAIL reset_alu fn=%0d A=%h B=%h exp=0", aluFunction, vectorA, vectorB); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (instReady !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", instReady); end
    endtask

    task automatic test_basic_add();
        extLoad(1, 8'h05);
        extLoad(2, 8'h03);
        runInst(0, 3, 1, 2, 1'b0, 0, 8'h00);
        refRegs[3] = aluRef(0, refRegs[1], refRegs[2]);
        checks++; if (obsFn !== 5'd0 || obsA !== 8'h05 || obsB !== 8'h03) begin errors++; $display("FAIL add_issue fn=%0d A=%h B=%h exp=0/05/03", obsFn, obsA, obsB); end
        checks++; if (obsReadyIssue !== 1'b0) begin errors++; $display("FAIL add_ready_in_issue got=%b exp=0", obsReadyIssue); end
        checks++; if (obsWbV !== 1'b1 || obsWbAddr !== 3'd3 || obsWbData !== 8'h08) begin errors++; $display("FAIL add_wb v=%b addr=%0d data=%h exp=1/3/08", obsWbV, obsWbAddr, obsWbData); end
        runInst(4, 0, 3, 0, 1'b0, 0, 8'h00);
        refRegs[0] = aluRef(4, refRegs[3], refRegs[0]);
        checks++; if (obsA !== 8'h08) begin errors++; $display("FAIL add_readback got=%h exp=08", obsA); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        instValid = 1'b1; instOp = 5'd7; instRd = 3'd6; instRs1 = 3'd1; instRs2 = 3'd2;
        @(negedge clk);
        instValid = 1'b0;
        checks++; if (illegalOp !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%b exp=1", illegalOp); end
        checks++; if (instReady !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_idle ready=%b busy=%b exp=1/0", instReady, busy); end
        checks++; if (wbValid !== 1'b0) begin errors++; $display("FAIL illegal_wb1 got=%b exp=0", wbValid); end
        @(negedge clk);
        checks++; if (illegalOp !== 1'b0 || wbValid !== 1'b0) begin errors++; $display("FAIL illegal_after pulse=%b wb=%b exp=0/0", illegalOp, wbValid); end
    endtask

    task automatic test_flags();
        extLoad(1, 8'h7F);
        extLoad(2, 8'h01);
        runInst(0, 4, 1, 2, 1'b0, 0, 8'h00);
        refRegs[4] = aluRef(0, refRegs[1], refRegs[2]);
        checks++; if (obsWbData !== 8'h80) begin errors++; $display("FAIL ovf_add_data got=%h exp=80", obsWbData); end
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (obsOvf !== 1'b1 || obsZero !== 1'b0) begin errors++; $display("FAIL ovf_add_flags ovf=%b zero=%b exp=1/0", obsOvf, obsZero); end
`endif
        runInst(1, 5, 1, 1, 1'b0, 0, 8'h00);
        refRegs[5] = aluRef(1, refRegs[1], refRegs[1]);
        checks++; if (obsWbData !== 8'h00 || obsWbAddr !== 3'd5) begin errors++; $display("FAIL sub_zero_data data=%h addr=%0d exp=00/5", obsWbData, obsWbAddr); end
`ifdef ALU_ISSUE_FLAGS_EN
        checks++; if (obsZero !== 1'b1 || obsOvf !== 1'b0) begin errors++; $display("FAIL sub_zero_flags zero=%b ovf=%b exp=1/0", obsZero, obsOvf); end
`endif
    endtask

    // instValid held high: accepted every third cycle, later ops see earlier write-backs.
    task automatic test_back_to_back();
        int op, rd, rs1, rs2;
        logic [7:0] ea, eb, er;
        for (int k = 0; k < 3 * 24; k++) begin
            @(negedge clk);
            case (k % 3)
                0: begin
                    checks++; if (instReady !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, instReady); end
                    if (k == 0) begin op = 0; rd = 1; rs1 = 1; rs2 = 2; end
                    else if (k == 3) begin op = 0; rd = 5; rs1 = 1; rs2 = 1; end
                    else begin op = randLegalOp(); rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); end
                    ea = refRegs[rs1]; eb = refRegs[rs2]; er = aluRef(op, ea, eb);
                    instValid = 1'b1; instOp = 5'(op); instRd = 3'(rd); instRs1 = 3'(rs1); instRs2 = 3'(rs2);
                end
                1: begin
                    checks++; if (instReady !== 1'b0 || aluFunction !== 5'(op) || vectorA !== ea || vectorB !== eb) begin
                        errors++; $display("FAIL b2b_issue k=%0d ready=%b fn=%0d A=%h B=%h exp=0/%0d/%h/%h", k, instReady, aluFunction, vectorA, vectorB, op, ea, eb);
                    end
                end
                default: begin
                    checks++; if (wbValid !== 1'b1 || wbAddr !== 3'(rd) || wbData !== er || instReady !== 1'b0) begin
                        errors++; $display("FAIL b2b_wb k=%0d v=%b addr=%0d data=%h exp=1/%0d/%h", k, wbValid, wbAddr, wbData, rd, er);
                    end
`ifdef ALU_ISSUE_FLAGS_EN
                    checks++; if (zeroFlag !== (er == 8'h00) || ovfFlag !== ovfRef(op, ea, eb)) begin
                        errors++; $display("FAIL b2b_flags k=%0d zero=%b ovf=%b exp=%b/%b", k, zeroFlag, ovfFlag, (er == 8'h00), ovfRef(op, ea, eb));
                    end
`endif
                    refRegs[rd] = er;
                end
            endcase
        end
        instValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ext_collision();
        logic [7:0] r6, r2;
        r6 = aluRef(0, refRegs[1], refRegs[2]);
        runInst(0, 6, 1, 2, 1'b1, 6, 8'hAA);
        refRegs[6] = r6;
        r2 = aluRef(2, refRegs[6], refRegs[4]);
        runInst(2, 2, 6, 4, 1'b1, 3, 8'h5C);
        refRegs[2] = r2; refRegs[3] = 8'h5C;
        runInst(4, 0, 6, 3, 1'b0, 0, 8'h00);
        refRegs[0] = aluRef(4, refRegs[6], refRegs[3]);
        checks++; if (obsA !== r6) begin errors++; $display("FAIL collide_wb_wins got=%h exp=%h", obsA, r6); end
        checks++; if (obsB !== 8'h5C) begin errors++; $display("FAIL collide_other_ext got=%h exp=5c", obsB); end
        runInst(4, 0, 2, 0, 1'b0, 0, 8'h00);
        checks++; if (obsA !== r2) begin errors++; $display("FAIL collide_other_wb got=%h exp=%h", obsA, r2); end
        refRegs[0] = aluRef(4, refRegs[2], refRegs[0]);
    endtask

    task automatic test_reset_in_wb();
        extLoad(7, 8'h11);
        @(negedge clk);
        instValid = 1'b1; instOp = 5'd0; instRd = 3'd7; instRs1 = 3'd7; instRs2 = 3'd7;
        @(negedge clk);
        instValid = 1'b0;
        @(negedge clk);
        checks++; if (wbValid !== 1'b1) begin errors++; $display("FAIL rstwb_pre got=%b exp=1", wbValid); end
        reset = 1'b1;
        #1;
        checks++; if (wbValid !== 1'b0 || busy !== 1'b0 || instReady !== 1'b1) begin
            errors++; $display("FAIL rstwb_abort wb=%b busy=%b ready=%b exp=0/0/1", wbValid, busy, instReady);
        end
        for (int i = 0; i < 8; i++) refRegs[i] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        runInst(4, 1, 7, 1, 1'b0, 0, 8'h00);
        checks++; if (obsA !== 8'h00 || obsWbData !== 8'h00) begin errors++; $display("FAIL rstwb_reg7 A=%h data=%h exp=00/00", obsA, obsWbData); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_illegal();
        test_flags();
        test_back_to_back();
        test_ext_collision();
        test_reset_in_wb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, datapath width.
REQ-002 SHALL have parameter OPCODE, default 5, ALU function code width.
REQ-003 SHALL have parameter REGS, default 8, register-file depth; address width RA = clog2(REGS).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 instValid  input  1  instruction offered.
REQ-007 instReady  output  1  block can accept an instruction.
REQ-008 instOp  input  OPCODE  ALU function code.
REQ-009 instRd / instRs1 / instRs2  input  RA each  destination and source register addresses.
REQ-010 extWe / extAddr / extData  input  1 / RA / BITS  external register-load port.
REQ-011 aluFunction  output  OPCODE  function code to the downstream ALU.
REQ-012 vectorA / vectorB  output  BITS each  operands to the ALU.
REQ-013 aluResult  input  BITS  combinational result from the ALU.
REQ-014 wbValid / wbAddr / wbData  output  1 / RA / BITS  write-back strobe, address, and data.
REQ-015 illegalOp  output  1  one-cycle pulse when an instruction is rejected.
REQ-016 busy  output  1  FSM not in IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; instReady = 1 only in IDLE.
REQ-018 Handshake: instValid && instReady at a rising edge SHALL latch op/rd/rs1/rs2 and move to ISSUE; instValid without instReady is ignored, with no buffering.
REQ-019 Legal opcodes SHALL be {0,1,2,3,4,11,12}; an illegal opcode accepted in IDLE SHALL pulse illegalOp for one cycle, stay in IDLE, and cause no write-back.
REQ-020 In ISSUE, the block SHALL drive aluFunction = latched op, vectorA = reg[rs1], vectorB = reg[rs2] (full width, including shift amounts), and capture aluResult at the end of the cycle.
REQ-021 Outside ISSUE, aluFunction/vectorA/vectorB SHALL be 0.
REQ-022 In WB, wbValid = 1 for one cycle with wbAddr = rd and wbData = captured result; reg[rd] is updated at the end of the WB cycle.
REQ-023 Latency: accept edge at cycle N; ISSUE at N+1; WB at N+2; instReady high again at N+3; throughput is 1 instruction per 3 cycles.
REQ-024 Read-after-write: the next instruction reads in its ISSUE cycle, after the prior WB edge, so no hazard logic SHALL exist.
REQ-025 extWe SHALL write reg[extAddr] = extData on any cycle; when it collides with a WB write to the same address, WB wins; a WB write to a different address SHALL perform both writes.
REQ-026 rd == rs1 == rs2 SHALL be legal; operands are read before the write.

Reset
REQ-027 Reset SHALL asynchronously force FSM = IDLE and clear all registers, captured result, wbValid, illegalOp, and flags; instReady = 1 immediately after release.
REQ-028 Reset asserted in ISSUE or WB SHALL abort the instruction with no write-back.

Configuration
REQ-029 Macro ALU_ISSUE_FLAGS_EN, when defined, SHALL add outputs zeroFlag and ovfFlag (1 bit each), updated in WB: zero = (result == 0); ovf = signed two's-complement overflow for opcodes 0/1, else 0.
REQ-030 Without ALU_ISSUE_FLAGS_EN, those ports and their logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the opcode constants (ADD=0, SUB=1, XOR=2, AND=3, OR=4, SHL=11, SHR=12), the FSM state encoding, and the legal-opcode function.
REQ-032 The register file SHALL be a sub-module, alu_issue_regfile: 2 read ports, 2 write ports, WB priority.

Verification
REQ-033 ext load r1=0x05, r2=0x03; issue ADD rd=3 -> ISSUE shows aluFunction=0, A=0x05, B=0x03; WB shows wbAddr=3, wbData=0x08 (ALU model in the bench).
REQ-034 Issue op 7 -> illegalOp pulse for 1 cycle, instReady stays 1, no wbValid.
REQ-035 r1=0x7F, r2=0x01, ADD rd=4, FLAGS_EN -> wbData=0x80, ovfFlag=1, zeroFlag=0; SUB r1-r1 -> 0x00, zeroFlag=1.
REQ-036 Back-to-back ADD rd=1 then ADD reads r1 -> second instruction uses the updated value; instValid held high is accepted every 3rd cycle.
REQ-037 Reset asserted during WB -> wbValid drops immediately, the target register reads 0, FSM = IDLE.
REQ-038 extWe to rd in the same cycle as WB -> WB data retained.
